// File: rtl/rst_seq.sv
// Staged reset sequencer: releases the peripheral, memory and core resets in order.
// A soft reset re-runs the memory and core stages. All outputs are registered.
//
// state  | meaning
// HOLD   | in reset, waiting for int_rst to deassert
// PERIPH | counting PERIPH_DLY before peripheral release
// MEM    | counting MEM_DLY before memory release
// INIT   | init_req high, waiting for init_done or timeout
// CORE   | counting CORE_DLY before core release
// RUN    | fully released
// FAULT  | memory init timed out, core held in reset
module rst_seq #(
    parameter int PERIPH_DLY   = 16,
    parameter int MEM_DLY      = 8,
    parameter int INIT_TIMEOUT = 1024,
    parameter int CORE_DLY     = 4,
    parameter int CNT_W        = 11
) (
    input  logic       clk_i,
    input  logic       int_rst_i,
    input  logic       soft_rst_req_i,
    input  logic       init_done_i,
    output logic       periph_rst_n_o,
    output logic       mem_rst_n_o,
    output logic       core_rst_n_o,
    output logic       init_req_o,
    output logic       sys_ready_o,
    output logic       init_timeout_o,
    output logic [2:0] seq_state_o
);

    localparam logic [2:0] ST_HOLD   = 3'd0;
    localparam logic [2:0] ST_PERIPH = 3'd1;
    localparam logic [2:0] ST_MEM    = 3'd2;
    localparam logic [2:0] ST_INIT   = 3'd3;
    localparam logic [2:0] ST_CORE   = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    localparam logic [CNT_W-1:0] PERIPH_TC = CNT_W'(PERIPH_DLY - 1);
    localparam logic [CNT_W-1:0] MEM_TC    = CNT_W'(MEM_DLY - 1);
    localparam logic [CNT_W-1:0] INIT_TC   = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CORE_TC   = CNT_W'(CORE_DLY - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_q, periph_d;
    logic             mem_q, mem_d;
    logic             init_req_q, init_req_d;
    logic             run_q, run_d;
    logic             timeout_q, timeout_d;
    logic             soft_hit;

    always_ff @(posedge clk_i) begin
        if (!int_rst_i) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            periph_q   <= 1'b0;
            mem_q      <= 1'b0;
            init_req_q <= 1'b0;
            run_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            periph_q   <= periph_d;
            mem_q      <= mem_d;
            init_req_q <= init_req_d;
            run_q      <= run_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        soft_hit = soft_rst_req_i &&
                   (state_q inside {ST_MEM, ST_INIT, ST_CORE, ST_RUN, ST_FAULT});
        case (state_q)
            ST_HOLD:   state_d = ST_PERIPH;
            ST_PERIPH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == PERIPH_TC) state_d = ST_MEM;
            end
            ST_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == MEM_TC) state_d = ST_INIT;
            end
            ST_INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (init_done_i)           state_d = ST_CORE;
                else if (cnt_q == INIT_TC) state_d = ST_FAULT;
            end
            ST_CORE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CORE_TC) state_d = ST_RUN;
            end
            ST_RUN, ST_FAULT: ;
            default:   state_d = ST_HOLD;
        endcase
        // A soft restart in MEM stays in MEM, so the counter clear cannot rely on a state change
        if (soft_hit) begin
            state_d = ST_MEM;
            cnt_d   = '0;
        end else if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs are registered images of the next state, so they change on the same edge as the state
    always_comb begin
        periph_d   = state_d inside {ST_MEM, ST_INIT, ST_CORE, ST_RUN, ST_FAULT};
        mem_d      = state_d inside {ST_INIT, ST_CORE, ST_RUN, ST_FAULT};
        init_req_d = (state_d == ST_INIT);
        run_d      = (state_d == ST_RUN);
        timeout_d  = timeout_q || (state_d == ST_FAULT);
    end

    assign periph_rst_n_o = periph_q;
    assign mem_rst_n_o    = mem_q;
    assign core_rst_n_o   = run_q;
    assign init_req_o     = init_req_q;
    assign sys_ready_o    = run_q;
    assign init_timeout_o = timeout_q;
    assign seq_state_o    = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a default instance and a short-delay instance (INIT_TIMEOUT=4),
// checked every cycle against a timestamp-based model plus directed timing checks.
module tb_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic       soft_v[2];
    logic       done_v[2];
    logic       periph_w[2], mem_w[2], core_w[2], req_w[2], rdy_w[2], to_w[2];
    logic [2:0] st_w[2];

    rst_seq u_dut_a (
        .clk_i          (clk),
        .int_rst_i      (rst_v[0]),
        .soft_rst_req_i (soft_v[0]),
        .init_done_i    (done_v[0]),
        .periph_rst_n_o (periph_w[0]),
        .mem_rst_n_o    (mem_w[0]),
        .core_rst_n_o   (core_w[0]),
        .init_req_o     (req_w[0]),
        .sys_ready_o    (rdy_w[0]),
        .init_timeout_o (to_w[0]),
        .seq_state_o    (st_w[0])
    );

    rst_seq #(
        .PERIPH_DLY   (2),
        .MEM_DLY      (2),
        .INIT_TIMEOUT (4),
        .CORE_DLY     (2),
        .CNT_W        (11)
    ) u_dut_b (
        .clk_i          (clk),
        .int_rst_i      (rst_v[1]),
        .soft_rst_req_i (soft_v[1]),
        .init_done_i    (done_v[1]),
        .periph_rst_n_o (periph_w[1]),
        .mem_rst_n_o    (mem_w[1]),
        .core_rst_n_o   (core_w[1]),
        .init_req_o     (req_w[1]),
        .sys_ready_o    (rdy_w[1]),
        .init_timeout_o (to_w[1]),
        .seq_state_o    (st_w[1])
    );

    int checks   = 0;
    int failures = 0;

    // Model: current phase (numbered as the debug encoding) and the cycle it was entered
    int m_dly_p[2] = '{16, 2};
    int m_dly_m[2] = '{8, 2};
    int m_dly_t[2] = '{1024, 4};
    int m_dly_c[2] = '{4, 2};
    int m_phase[2];
    int m_t0[2];
    bit m_flag[2];
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int age;
        age = cyc - m_t0[k];
        if (!rst_v[k]) begin
            m_phase[k] = 0; m_flag[k] = 1'b0; m_t0[k] = cyc;
        end else if (soft_v[k] && m_phase[k] >= 2) begin
            m_phase[k] = 2; m_t0[k] = cyc;
        end else begin
            case (m_phase[k])
                0: begin m_phase[k] = 1; m_t0[k] = cyc; end
                1: if (age == m_dly_p[k]) begin m_phase[k] = 2; m_t0[k] = cyc; end
                2: if (age == m_dly_m[k]) begin m_phase[k] = 3; m_t0[k] = cyc; end
                3: if (done_v[k]) begin
                       m_phase[k] = 4; m_t0[k] = cyc;
                   end else if (age == m_dly_t[k]) begin
                       m_phase[k] = 6; m_t0[k] = cyc; m_flag[k] = 1'b1;
                   end
                4: if (age == m_dly_c[k]) begin m_phase[k] = 5; m_t0[k] = cyc; end
                default: ;
            endcase
        end
    endtask

    task automatic check_model(input int k);
        chk($sformatf("m%0d_periph", k), 32'(periph_w[k]), 32'(m_phase[k] >= 2));
        chk($sformatf("m%0d_mem", k),    32'(mem_w[k]),    32'(m_phase[k] >= 3));
        chk($sformatf("m%0d_req", k),    32'(req_w[k]),    32'(m_phase[k] == 3));
        chk($sformatf("m%0d_core", k),   32'(core_w[k]),   32'(m_phase[k] == 5));
        chk($sformatf("m%0d_rdy", k),    32'(rdy_w[k]),    32'(m_phase[k] == 5));
        chk($sformatf("m%0d_tout", k),   32'(to_w[k]),     32'(m_flag[k]));
        chk($sformatf("m%0d_state", k),  32'(st_w[k]),     32'(m_phase[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_model(0);
        check_model(1);
    endtask

    // Full power-on from HOLD on instance A with init_done tied high; i = 0 is E0
    task automatic power_on_a();
        rst_v[0] = 1'b1; done_v[0] = 1'b1; soft_v[0] = 1'b0;
        for (int i = 0; i <= 29; i++) begin
            tick();
            case (i)
                15: chk("po_periph_pre", 32'(periph_w[0]), 0);
                16: chk("po_periph", 32'(periph_w[0]), 1);
                23: chk("po_mem_pre", 32'(mem_w[0]), 0);
                24: begin
                    chk("po_mem", 32'(mem_w[0]), 1);
                    chk("po_req", 32'(req_w[0]), 1);
                end
                25: chk("po_req_fall", 32'(req_w[0]), 0);
                28: chk("po_rdy_pre", 32'(rdy_w[0]), 0);
                29: begin
                    chk("po_rdy", 32'(rdy_w[0]), 1);
                    chk("po_core", 32'(core_w[0]), 1);
                    chk("po_state", 32'(st_w[0]), 5);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b0; soft_v[k] = 1'b0; done_v[k] = 1'b0;
            m_phase[k] = 0; m_t0[k] = 0; m_flag[k] = 1'b0;
        end
        repeat (5) tick();
        chk("rst_state", 32'(st_w[0]), 0);
        chk("rst_periph", 32'(periph_w[0]), 0);
        chk("rst_tout", 32'(to_w[0]), 0);

        power_on_a();

        // soft reset from RUN
        soft_v[0] = 1'b1;
        tick();
        soft_v[0] = 1'b0;
        chk("sr_mem", 32'(mem_w[0]), 0);
        chk("sr_core", 32'(core_w[0]), 0);
        chk("sr_rdy", 32'(rdy_w[0]), 0);
        chk("sr_periph", 32'(periph_w[0]), 1);
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 7)  chk("sr_mem_pre", 32'(mem_w[0]), 0);
            if (i == 8)  chk("sr_mem_rise", 32'(mem_w[0]), 1);
            if (i == 12) chk("sr_rdy_pre", 32'(rdy_w[0]), 0);
            if (i == 13) chk("sr_rdy_rise", 32'(rdy_w[0]), 1);
        end

        // int_rst pulse while in INIT, then a clean restart
        rst_v[0] = 1'b0; tick();
        rst_v[0] = 1'b1; done_v[0] = 1'b0;
        for (int i = 0; i <= 26; i++) tick();
        chk("ir_in_init", 32'(st_w[0]), 3);
        rst_v[0] = 1'b0; tick();
        chk("ir_state", 32'(st_w[0]), 0);
        chk("ir_mem", 32'(mem_w[0]), 0);
        chk("ir_req", 32'(req_w[0]), 0);
        chk("ir_periph", 32'(periph_w[0]), 0);
        power_on_a();

        // init timeout into FAULT
        rst_v[0] = 1'b0; tick();
        rst_v[0] = 1'b1; done_v[0] = 1'b0;
        for (int i = 0; i <= 1048; i++) begin
            tick();
            if (i == 1047) begin
                chk("to_flag_pre", 32'(to_w[0]), 0);
                chk("to_state_pre", 32'(st_w[0]), 3);
            end
            if (i == 1048) begin
                chk("to_flag", 32'(to_w[0]), 1);
                chk("to_state", 32'(st_w[0]), 6);
                chk("to_req", 32'(req_w[0]), 0);
            end
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("fault_core", 32'(core_w[0]), 0);
        end

        // soft reset out of FAULT keeps the sticky flag
        soft_v[0] = 1'b1; done_v[0] = 1'b1;
        tick();
        soft_v[0] = 1'b0;
        chk("fs_state", 32'(st_w[0]), 2);
        chk("fs_mem", 32'(mem_w[0]), 0);
        chk("fs_tout", 32'(to_w[0]), 1);
        for (int i = 1; i <= 13; i++) tick();
        chk("fs_rdy", 32'(rdy_w[0]), 1);
        chk("fs_run", 32'(st_w[0]), 5);
        chk("fs_tout_kept", 32'(to_w[0]), 1);

        // instance B: init_done on the same edge as the timeout compare
        rst_v[1] = 1'b0; tick();
        rst_v[1] = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            done_v[1] = (i == 8);
            tick();
        end
        done_v[1] = 1'b0;
        chk("b_tie_state", 32'(st_w[1]), 4);
        chk("b_tie_tout", 32'(to_w[1]), 0);
        chk("b_tie_req", 32'(req_w[1]), 0);
        tick();
        chk("b_core_pre", 32'(rdy_w[1]), 0);
        tick();
        chk("b_run", 32'(rdy_w[1]), 1);

        // instance B: same edge without init_done times out
        rst_v[1] = 1'b0; tick();
        rst_v[1] = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick();
            if (i == 7) chk("b_to_pre", 32'(st_w[1]), 3);
        end
        chk("b_to_state", 32'(st_w[1]), 6);
        chk("b_to_flag", 32'(to_w[1]), 1);

        // randomized traffic on both instances, model-checked every cycle
        for (int n = 0; n < 4000; n++) begin
            rst_v[0]  = ($urandom_range(0, 299) != 0);
            soft_v[0] = ($urandom_range(0, 59) == 0);
            done_v[0] = ($urandom_range(0, 7) == 0);
            rst_v[1]  = ($urandom_range(0, 149) != 0);
            soft_v[1] = ($urandom_range(0, 39) == 0);
            done_v[1] = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset sequencer that sits directly downstream of the reset conditioning unit. It consumes the conditioned, debounced internal reset and releases the peripheral, memory and core resets in a fixed order. Memory initialisation is gated by a request/done handshake with a timeout, and the block supports a soft reset that re-runs the memory and core stages without touching the peripherals.

## Interface
- PERIPH_DLY, 16: cycles from sequence start until peripheral reset release; range 1..2^CNT_W.
- MEM_DLY, 8: cycles from peripheral release (or soft restart) until memory reset release; range 1..2^CNT_W.
- INIT_TIMEOUT, 1024: maximum cycles spent waiting for init_done; range 1..2^CNT_W.
- CORE_DLY, 4: cycles from init_done until core reset release; range 1..2^CNT_W.
- CNT_W, 11: width of the shared stage counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- int_rst  in  1  conditioned reset; synchronous, active-low; dominates everything.
- soft_rst_req  in  1  soft reset request; sampled each edge; level or pulse.
- init_done  in  1  memory initialiser completion; sampled only in INIT.
- periph_rst_n  out  1  peripheral reset, active-low.
- mem_rst_n  out  1  memory reset, active-low.
- core_rst_n  out  1  core reset, active-low.
- init_req  out  1  memory initialisation request, held high until done or timeout.
- sys_ready  out  1  high once the core is released.
- init_timeout  out  1  sticky fault flag; cleared only by int_rst.
- seq_state  out  3  current state encoding, for debug.

## Operation
- States and encodings: HOLD=0, PERIPH=1, MEM=2, INIT=3, CORE=4, RUN=5, FAULT=6. Encoding 7 is unused and recovers to HOLD.
- Reset: at any edge with int_rst=0, the block goes to HOLD with counter=0.
  - All outputs go to 0: periph_rst_n, mem_rst_n, core_rst_n, init_req, sys_ready, init_timeout.
  - seq_state=0.
- HOLD: at the first edge with int_rst=1, go to PERIPH with counter=0.
- PERIPH: counter increments each edge. At the edge where counter==PERIPH_DLY-1: periph_rst_n<=1, go to MEM, counter<=0.
- MEM: at the edge where counter==MEM_DLY-1: mem_rst_n<=1, init_req<=1, go to INIT, counter<=0.
- INIT:
  - If init_done=1: init_req<=0, go to CORE, counter<=0.
  - Else, at the edge where counter==INIT_TIMEOUT-1: init_req<=0, init_timeout<=1, go to FAULT.
  - If init_done and the timeout condition occur on the same edge, init_done wins: normal path, no flag.
- CORE: at the edge where counter==CORE_DLY-1: core_rst_n<=1, sys_ready<=1, go to RUN.
- RUN: hold indefinitely.
- FAULT: core_rst_n=0, sys_ready=0, mem_rst_n=1, periph_rst_n=1. The block stays here until int_rst or soft_rst_req.
- Soft reset: soft_rst_req=1 at an edge in MEM, INIT, CORE, RUN or FAULT:
  - mem_rst_n<=0, core_rst_n<=0, init_req<=0, sys_ready<=0.
  - Go to MEM with counter<=0.
  - periph_rst_n and init_timeout are unchanged.
- soft_rst_req is ignored in HOLD and PERIPH.
- Priority: int_rst > soft_rst_req > init_done > timeout > delay expiry.
- Counter: CNT_W-bit, cleared on every state change. It never wraps, because every terminal compare is below 2^CNT_W.

## Timing
- E0 is the first edge sampling int_rst=1. P, M, C and T are PERIPH_DLY, MEM_DLY, CORE_DLY and INIT_TIMEOUT.
- periph_rst_n rises after edge E0+P.
- mem_rst_n and init_req rise after edge E0+P+M.
- init_done is first sampled at edge E0+P+M+1. If it is sampled high at edge Ed, init_req falls after Ed and core_rst_n/sys_ready rise after Ed+C.
- Minimum total with defaults: core released after edge E0+29.
- Timeout: FAULT and init_timeout=1 after edge E0+P+M+T.
- Soft reset sampled at edge Es:
  - mem_rst_n, core_rst_n and sys_ready are 0 after Es.
  - mem_rst_n and init_req rise after Es+M.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Power-on, defaults, init_done tied to 1: int_rst low for 5 cycles, then high at E0 -> periph_rst_n=1 after E0+16, mem_rst_n=init_req=1 after E0+24, init_req=0 after E0+25, core_rst_n=sys_ready=1 after E0+29, seq_state=5.
- init_done held at 0 -> init_timeout=1, seq_state=6, init_req=0 after E0+1048; core_rst_n stays 0 for 200 further cycles.
- In RUN, a 1-cycle soft_rst_req at Es -> mem_rst_n=core_rst_n=sys_ready=0 after Es while periph_rst_n stays 1; mem_rst_n=1 after Es+8; sys_ready=1 after Es+13 with init_done=1.
- int_rst pulled low for 1 cycle while in INIT -> all outputs 0 and seq_state=0 at that edge; a full sequence restarts with the same timing as scenario 1.
- With INIT_TIMEOUT=4, init_done first asserted on the edge where counter==3 -> CORE entered, init_timeout=0.
- In FAULT, soft_rst_req=1 -> MEM restart, init_timeout stays 1; with init_done=1 the block reaches RUN with init_timeout still 1.
